// File: rtl/encoder_83.sv
// Registered 8-to-3 encoder with one-hot check; y is tri-stated whenever
// the last accepted sample did not produce a legal index.
module encoder_83 #(
  parameter bit PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] i,
  output logic [2:0] y,
  output logic       valid,
  output logic       none,
  output logic       multi
);

  logic [2:0] index_reg, index_next;
  logic       valid_reg, valid_next;
  logic       none_reg, none_next;
  logic       multi_reg, multi_next;

  // seen[k] is high once any bit below k is set; a set bit that is already
  // "seen" marks a second request, giving a symmetric multi-hot test.
  logic [8:0] seen;
  logic [7:0] dup;
  logic       multi_hot;
  logic       zero_in;
  logic [2:0] high_idx;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dup
      assign seen[gi+1] = seen[gi] | i[gi];
      assign dup[gi]    = seen[gi] & i[gi];
    end
  endgenerate

  assign multi_hot = |dup;
  assign zero_in   = ~seen[8];

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    high_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (i[k]) high_idx = 3'(k);
    end
  end

  always_comb begin
    index_next = index_reg;
    valid_next = valid_reg;
    none_next  = none_reg;
    multi_next = multi_reg;
    if (en) begin
      if (zero_in) begin
        valid_next = 1'b0;
        none_next  = 1'b1;
        multi_next = 1'b0;
      end else if (multi_hot && !PRIORITY) begin
        valid_next = 1'b0;
        none_next  = 1'b0;
        multi_next = 1'b1;
      end else begin
        index_next = high_idx;
        valid_next = 1'b1;
        none_next  = 1'b0;
        multi_next = multi_hot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg <= 3'd0;
      valid_reg <= 1'b0;
      none_reg  <= 1'b0;
      multi_reg <= 1'b0;
    end else begin
      index_reg <= index_next;
      valid_reg <= valid_next;
      none_reg  <= none_next;
      multi_reg <= multi_next;
    end
  end

  assign valid = valid_reg;
  assign none  = none_reg;
  assign multi = multi_reg;
  assign y     = valid_reg ? index_reg : 3'bzzz;

endmodule

// File: tb/tb_encoder_83.sv
// Directed and random checks of encoder_83 in strict (dut0) and priority
// (dut1) modes, both driven by the same stimulus.
module tb_encoder_83;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] i;
  wire  [2:0] y0, y1;
  logic       valid0, none0, multi0;
  logic       valid1, none1, multi1;

  // Reads back however this simulator resolves an undriven 3-bit net,
  // so a released y can be compared against it.
  wire  [2:0] z_probe;
  assign z_probe = 3'bzzz;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encoder_83 #(.PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .y(y0), .valid(valid0), .none(none0), .multi(multi0)
  );

  encoder_83 #(.PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .y(y1), .valid(valid1), .none(none1), .multi(multi1)
  );

  typedef struct {
    logic [7:0] i;
    logic [2:0] y0;
    logic       v0, n0, m0;
    logic [2:0] y1;
    logic       v1, n1, m1;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name,
                       input logic [2:0] ey0, input logic ev0, input logic en0, input logic em0,
                       input logic [2:0] ey1, input logic ev1, input logic en1, input logic em1);
    logic [2:0] wy0, wy1;
    wy0 = ev0 ? ey0 : z_probe;
    wy1 = ev1 ? ey1 : z_probe;
    n_vec++;
    if (y0 !== wy0 || valid0 !== ev0 || none0 !== en0 || multi0 !== em0 ||
        y1 !== wy1 || valid1 !== ev1 || none1 !== en1 || multi1 !== em1) begin
      n_bad++;
      $display("FAIL %s i=%b: got p0 y=%b v=%b n=%b m=%b p1 y=%b v=%b n=%b m=%b, need p0 y=%b v=%b n=%b m=%b p1 y=%b v=%b n=%b m=%b",
               name, i, y0, valid0, none0, multi0, y1, valid1, none1, multi1,
               wy0, ev0, en0, em0, wy1, ev1, en1, em1);
    end else begin
      $display("ok   %s i=%b p0 y=%b v=%b n=%b m=%b p1 y=%b v=%b n=%b m=%b",
               name, i, y0, valid0, none0, multi0, y1, valid1, none1, multi1);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [7:0] v, input bit prio,
                       output logic [2:0] ey, output logic ev, output logic en_f, output logic em);
    int cnt;
    int hi;
    cnt = 0;
    hi  = 0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) begin
        cnt++;
        hi = b;
      end
    end
    ey   = 3'(hi);
    en_f = (cnt == 0);
    em   = (cnt > 1);
    ev   = (cnt == 1) || (prio && cnt > 1);
  endtask

  initial begin
    logic [2:0] ry0, ry1;
    logic       rv0, rn0, rm0, rv1, rn1, rm1;
    logic [7:0] rv;

    // walking one, then illegal / priority cases
    for (int k = 0; k < 8; k++) begin
      tbl[k] = '{8'(1 << k), 3'(k), 1'b1, 1'b0, 1'b0, 3'(k), 1'b1, 1'b0, 1'b0};
    end
    tbl[8]  = '{8'b0010_0100, 3'b000, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'b1111_1001, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{8'b1000_0001, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{8'b0100_0000, 3'b110, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    en  = 1'b1;
    i   = 8'b0000_0001;
    step();
    check("reset_1", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check("reset_2", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("reset_release", 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      i = tbl[t].i;
      step();
      check($sformatf("table_%0d", t), tbl[t].y0, tbl[t].v0, tbl[t].n0, tbl[t].m0,
            tbl[t].y1, tbl[t].v1, tbl[t].n1, tbl[t].m1);
    end

    // enable hold
    i = 8'b0001_0000;
    step();
    check("hold_load", 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    i  = 8'b0000_0010;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold_%0d", c), 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check("hold_release", 3'b001, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);

    // an illegal vector held off by en=0 must not disturb outputs
    en = 1'b0;
    i  = 8'b0000_0000;
    step();
    check("hold_zero", 3'b001, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);

    // reset wins over en=0
    rst = 1'b1;
    step();
    check("reset_over_en", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;

    for (int r = 0; r < 32; r++) begin
      rv = 8'($urandom_range(0, 255));
      if (r % 4 == 0) rv = 8'(1 << $urandom_range(0, 7));
      i = rv;
      model(rv, 1'b0, ry0, rv0, rn0, rm0);
      model(rv, 1'b1, ry1, rv1, rn1, rm1);
      step();
      check($sformatf("rand_%0d", r), ry0, rv0, rn0, rm0, ry1, rv1, rn1, rm1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
